mfi_retire_serializer: RTL and testbench

- Producer end of the MFI trace interface.
- Accepts up to two retirement records per cycle from a dual-issue core's commit stage. Records are buffered in a small FIFO.
- Emits at most one MFI record per cycle, in program order, with a monotonically increasing mfi_order.
- Its outputs drive the MFI_INPUTS of the formal property checks.

---
 rtl/mfi_pkg.sv | 15 +
 rtl/mfi_fifo_2w1r.sv | 60 ++++++
 rtl/mfi_retire_serializer.sv | 113 +++++++++++
 tb/tb_mfi_retire_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mfi_pkg.sv
// Shared widths and the record type carried from the retire stage to the MFI trace port.
package mfi_pkg;

  localparam int MFI_REG_W   = 4;
  localparam int MFI_ORDER_W = 32;

  typedef struct packed {
    logic [MFI_REG_W-1:0]   src1;
    logic [MFI_REG_W-1:0]   src2;
    logic [MFI_REG_W-1:0]   src3;
    logic [MFI_REG_W-1:0]   dest;
    logic [MFI_ORDER_W-1:0] order;
  } mfi_rec_t;

endpackage

// File: rtl/mfi_fifo_2w1r.sv
// Record FIFO with two lane-ordered write ports and one read port; owns count and pointers.
module mfi_fifo_2w1r
  import mfi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr0_en_i,
  input  mfi_rec_t                   wr0_data_i,
  input  logic                       wr1_en_i,
  input  mfi_rec_t                   wr1_data_i,
  input  logic                       rd_en_i,
  output mfi_rec_t                   rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mfi_rec_t        mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW-1:0]   tail_p1;
  logic [CW-1:0]   count_q, count_d;

  // Writes are compacted: wr1 is only ever used together with wr0, so it lands one slot behind.
  assign tail_p1   = tail_q + AW'(1);
  assign rd_data_o = mem_q[head_q];
  assign count_o   = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(wr0_en_i) + CW'(wr1_en_i) - CW'(rd_en_i);
    if (rd_en_i) head_d = head_q + AW'(1);
    if (wr0_en_i) tail_d = tail_q + AW'(1) + AW'(wr1_en_i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr0_en_i) mem_q[tail_q] <= wr0_data_i;
    if (wr0_en_i && wr1_en_i) mem_q[tail_p1] <= wr1_data_i;
  end

  a_count_bound: assert property (@(posedge clock) disable iff (reset) count_q <= CW'(DEPTH));
  a_lane_compact: assert property (@(posedge clock) disable iff (reset) wr1_en_i |-> wr0_en_i);

endmodule

// File: rtl/mfi_retire_serializer.sv
// Serializes up to two retirements per cycle into one program-ordered MFI record per cycle.
module mfi_retire_serializer
  import mfi_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ret0_valid,
  input  logic [MFI_REG_W-1:0]   ret0_src1_addr,
  input  logic [MFI_REG_W-1:0]   ret0_src2_addr,
  input  logic [MFI_REG_W-1:0]   ret0_src3_addr,
  input  logic [MFI_REG_W-1:0]   ret0_dest_addr,
  input  logic                   ret1_valid,
  input  logic [MFI_REG_W-1:0]   ret1_src1_addr,
  input  logic [MFI_REG_W-1:0]   ret1_src2_addr,
  input  logic [MFI_REG_W-1:0]   ret1_src3_addr,
  input  logic [MFI_REG_W-1:0]   ret1_dest_addr,
  output logic                   ret_ready,
  output logic                   mfi_valid,
  output logic [MFI_ORDER_W-1:0] mfi_order,
  output logic [MFI_REG_W-1:0]   mfi_src1_addr,
  output logic [MFI_REG_W-1:0]   mfi_src2_addr,
  output logic [MFI_REG_W-1:0]   mfi_src3_addr,
  output logic [MFI_REG_W-1:0]   mfi_dest_addr
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int ORDER_W = MFI_ORDER_W;

  logic [ORDER_W-1:0] next_order_q, next_order_d;
  logic [CW-1:0]      count;
  logic               wr0, wr1, pop;
  mfi_rec_t           rec0, rec1, head;
  mfi_rec_t           out_q;
  logic               out_valid_q;

  // Handshake: ret_ready depends only on occupancy and guarantees two free slots; a lane
  // retires when retN_valid && ret_ready in the same cycle, otherwise its inputs are dropped.
  // The MFI side has no ready: a record is presented for exactly one cycle with mfi_valid.
  assign ret_ready = (count <= CW'(DEPTH - 2));
  assign pop       = (count != '0);

  always_comb begin
    wr0          = 1'b0;
    wr1          = 1'b0;
    rec0         = '0;
    rec1         = '0;
    next_order_d = next_order_q;
    if (ret_ready) begin
      if (ret0_valid) begin
        wr0        = 1'b1;
        rec0.src1  = ret0_src1_addr;
        rec0.src2  = ret0_src2_addr;
        rec0.src3  = ret0_src3_addr;
        rec0.dest  = ret0_dest_addr;
        rec0.order = next_order_q;
        if (ret1_valid) begin
          wr1        = 1'b1;
          rec1.src1  = ret1_src1_addr;
          rec1.src2  = ret1_src2_addr;
          rec1.src3  = ret1_src3_addr;
          rec1.dest  = ret1_dest_addr;
          rec1.order = next_order_q + ORDER_W'(1);
        end
      end else if (ret1_valid) begin
        // A lone lane-1 retirement is compacted onto write port 0.
        wr0        = 1'b1;
        rec0.src1  = ret1_src1_addr;
        rec0.src2  = ret1_src2_addr;
        rec0.src3  = ret1_src3_addr;
        rec0.dest  = ret1_dest_addr;
        rec0.order = next_order_q;
      end
      next_order_d = next_order_q + ORDER_W'(wr0) + ORDER_W'(wr1);
    end
  end

  mfi_fifo_2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr0_en_i   (wr0),
    .wr0_data_i (rec0),
    .wr1_en_i   (wr1),
    .wr1_data_i (rec1),
    .rd_en_i    (pop),
    .rd_data_o  (head),
    .count_o    (count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      next_order_q <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      next_order_q <= next_order_d;
      out_valid_q  <= pop;
      out_q        <= pop ? head : '0;
    end
  end

  assign mfi_valid     = out_valid_q;
  assign mfi_order     = out_q.order;
  assign mfi_src1_addr = out_q.src1;
  assign mfi_src2_addr = out_q.src2;
  assign mfi_src3_addr = out_q.src3;
  assign mfi_dest_addr = out_q.dest;

  a_order_step: assert property (@(posedge clock) disable iff (reset)
    (out_valid_q && $past(out_valid_q)) |-> (out_q.order == $past(out_q.order) + ORDER_W'(1)));

endmodule

// File: tb/tb_mfi_retire_serializer.sv
// Directed bench for the MFI retire serializer with an expected-record queue.
module tb_mfi_retire_serializer;
  import mfi_pkg::*;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ret0_valid, ret1_valid;
  logic [3:0]  ret0_src1_addr, ret0_src2_addr, ret0_src3_addr, ret0_dest_addr;
  logic [3:0]  ret1_src1_addr, ret1_src2_addr, ret1_src3_addr, ret1_dest_addr;
  logic        ret_ready, mfi_valid;
  logic [31:0] mfi_order;
  logic [3:0]  mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr;

  logic [47:0] exp_q[$];
  logic [31:0] mdl_order;
  logic [31:0] last_order;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_seen   = 0;
  bit          saw_not_ready = 1'b0;

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  mfi_retire_serializer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ret0_valid     (ret0_valid),
    .ret0_src1_addr (ret0_src1_addr),
    .ret0_src2_addr (ret0_src2_addr),
    .ret0_src3_addr (ret0_src3_addr),
    .ret0_dest_addr (ret0_dest_addr),
    .ret1_valid     (ret1_valid),
    .ret1_src1_addr (ret1_src1_addr),
    .ret1_src2_addr (ret1_src2_addr),
    .ret1_src3_addr (ret1_src3_addr),
    .ret1_dest_addr (ret1_dest_addr),
    .ret_ready      (ret_ready),
    .mfi_valid      (mfi_valid),
    .mfi_order      (mfi_order),
    .mfi_src1_addr  (mfi_src1_addr),
    .mfi_src2_addr  (mfi_src2_addr),
    .mfi_src3_addr  (mfi_src3_addr),
    .mfi_dest_addr  (mfi_dest_addr)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    mdl_order = '0;
  endtask

  // driver + scoreboard: one retire cycle, fields packed {src1,src2,src3,dest}
  task automatic drive_cycle(input logic v0, input logic [15:0] f0,
                             input logic v1, input logic [15:0] f1);
    logic        exp_ready, exp_v;
    logic [47:0] exp_rec;
    {ret0_src1_addr, ret0_src2_addr, ret0_src3_addr, ret0_dest_addr} = f0;
    {ret1_src1_addr, ret1_src2_addr, ret1_src3_addr, ret1_dest_addr} = f1;
    ret0_valid = v0;
    ret1_valid = v1;
    exp_ready = (exp_q.size() <= DEPTH - 2);
    check("ret_ready", 64'(ret_ready), 64'(exp_ready));
    if (!exp_ready) saw_not_ready = 1'b1;
    exp_v   = 1'b0;
    exp_rec = '0;
    if (exp_q.size() > 0) begin
      exp_rec = exp_q.pop_front();
      exp_v   = 1'b1;
    end
    if (exp_ready) begin
      if (v0) begin exp_q.push_back({mdl_order, f0}); mdl_order++; end
      if (v1) begin exp_q.push_back({mdl_order, f1}); mdl_order++; end
    end
    tick();
    ret0_valid = 1'b0;
    ret1_valid = 1'b0;
    check("mfi_valid", 64'(mfi_valid), 64'(exp_v));
    check("mfi_record",
          64'({mfi_order, mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr}),
          64'(exp_rec));
    if (mfi_valid) begin
      n_seen++;
      last_order = mfi_order;
    end
  endtask

  initial begin
    ret0_valid = 1'b0; ret1_valid = 1'b0;
    {ret0_src1_addr, ret0_src2_addr, ret0_src3_addr, ret0_dest_addr} = '0;
    {ret1_src1_addr, ret1_src2_addr, ret1_src3_addr, ret1_dest_addr} = '0;
    last_order = '0;

    // reset state
    do_reset();
    check("rst_valid", 64'(mfi_valid), 64'(0));
    check("rst_fields", 64'({mfi_order, mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr}), 64'(0));
    check("rst_ready", 64'(ret_ready), 64'(1));

    // 1: single lane-0 retire
    drive_cycle(1'b1, 16'h1235, 1'b0, 16'h0000);
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t1_order", 64'(mfi_order), 64'(0));
    check("t1_src", 64'({mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr}), 64'(16'h1235));
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t1_idle", 64'(mfi_valid), 64'(0));

    // 2: dual retire
    do_reset();
    drive_cycle(1'b1, 16'h0004, 1'b1, 16'h0006);
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t2_first", 64'({mfi_valid, mfi_order, mfi_dest_addr}), {27'd0, 1'b1, 32'd0, 4'd4});
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t2_second", 64'({mfi_valid, mfi_order, mfi_dest_addr}), {27'd0, 1'b1, 32'd1, 4'd6});

    // 3: lane-1 only
    drive_cycle(1'b0, 16'h0000, 1'b1, 16'h0007);
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t3_lane1", 64'({mfi_valid, mfi_order, mfi_dest_addr}), {27'd0, 1'b1, 32'd2, 4'd7});
    drive_cycle(1'b1, 16'h0003, 1'b0, 16'h0000);
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t3_next", 64'(mfi_order), 64'(3));

    // 4: dual retire every cycle, backpressure drops
    do_reset();
    saw_not_ready = 1'b0;
    n_seen = 0;
    for (int i = 0; i < 10; i++)
      drive_cycle(1'b1, {12'h123, 4'(2 * i)}, 1'b1, {12'h456, 4'(2 * i + 1)});
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t4_backpressure", 64'(saw_not_ready), 64'(1));
    check("t4_count", 64'(n_seen), 64'(16));
    check("t4_last_order", 64'(last_order), 64'(15));

    // 5: order counter wrap
    force dut.next_order_q = 32'hFFFF_FFFF;
    mdl_order = 32'hFFFF_FFFF;
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    release dut.next_order_q;
    drive_cycle(1'b1, 16'h000A, 1'b1, 16'h000B);
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t5_top", 64'({mfi_valid, mfi_order}), {31'd0, 1'b1, 32'hFFFF_FFFF});
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t5_wrap", 64'({mfi_valid, mfi_order}), {31'd0, 1'b1, 32'h0000_0000});

    // 6: reset with five entries buffered
    do_reset();
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 16'h0001, 1'b1, 16'h0002);
    reset = 1'b1;
    tick();
    check("t6_valid", 64'(mfi_valid), 64'(0));
    check("t6_ready", 64'(ret_ready), 64'(1));
    reset = 1'b0;
    exp_q.delete();
    mdl_order = '0;
    drive_cycle(1'b1, 16'h0009, 1'b0, 16'h0000);
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);
    check("t6_restart", 64'({mfi_valid, mfi_order, mfi_dest_addr}), {27'd0, 1'b1, 32'd0, 4'd9});
    drive_cycle(1'b0, 16'h0000, 1'b0, 16'h0000);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
